// File: rtl/quadrature_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : quadrature_decoder
//  Description : Two-phase (A/B) incremental-encoder front end. Synchronises
//                and debounces both channels, decodes x4 Gray transitions into
//                one-cycle step pulses with a direction flag, and flags and
//                counts illegal (double-bit) transitions.
//  Ports       :
//    clk        in   1          single clock, all logic on posedge
//    rst        in   1          synchronous reset, active-high
//    en         in   1          1 = emit step/err, 0 = track inputs silently
//    enc_a      in   1          raw encoder channel A (asynchronous)
//    enc_b      in   1          raw encoder channel B (asynchronous)
//    step       out  1          one-cycle pulse per valid quadrature transition
//    up_down    out  1          direction of most recent valid step (1 = up)
//    err        out  1          one-cycle pulse on illegal transition
//    err_count  out  ERR_CNT_W  saturating count of illegal transitions
//    ready      out  1          high once the decoder has left INIT
//  Revision    : 1.0  initial release
// ============================================================================
module quadrature_decoder #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ERR_CNT_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 enc_a,
    input  logic                 enc_b,
    output logic                 step,
    output logic                 up_down,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic                 ready
);

    localparam int                  C_CNT_W      = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [C_CNT_W-1:0]  C_CNT_MAX    = C_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam int                  C_SETTLE_W   = $clog2(SYNC_STAGES + 1);
    localparam logic [C_SETTLE_W-1:0] C_SETTLE_MAX = C_SETTLE_W'(SYNC_STAGES);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Channel index 1 = A, 0 = B throughout.
    logic [SYNC_STAGES-1:0]        r_sync_a;
    logic [SYNC_STAGES-1:0]        r_sync_b;
    logic [1:0]                    w_sync;
    logic [1:0]                    r_filt;
    logic [1:0][C_CNT_W-1:0]       r_cnt;
    logic [1:0]                    r_prev;
    logic [C_SETTLE_W-1:0]         r_settle;
    state_t                        r_state;
    logic                          w_quiet;
    logic [1:0]                    w_delta;

    // Position along the up sequence 00->01->11->10 as a binary index, so a
    // modulo-4 difference directly gives +1 (up), -1 (down) or 2 (illegal).
    function automatic logic [1:0] gray_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    assign w_sync  = {r_sync_a[SYNC_STAGES-1], r_sync_b[SYNC_STAGES-1]};
    assign w_quiet = (w_sync == r_filt) && (r_cnt[1] == '0) && (r_cnt[0] == '0);
    assign w_delta = gray_pos(r_filt) - gray_pos(r_prev);

    // ------------------------------------------------------------------
    // Synchronisers and per-channel debounce filters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync_a <= '0;
            r_sync_b <= '0;
            r_filt   <= '0;
            r_cnt    <= '0;
        end else begin
            r_sync_a <= {r_sync_a[SYNC_STAGES-2:0], enc_a};
            r_sync_b <= {r_sync_b[SYNC_STAGES-2:0], enc_b};
            for (int i = 0; i < 2; i++) begin
                if (w_sync[i] == r_filt[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == C_CNT_MAX) begin
                    r_filt[i] <= w_sync[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + C_CNT_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Decode FSM. INIT waits until the channels have been quiet for
    // SYNC_STAGES+1 consecutive cycles: the synchroniser chains come out of
    // reset at 0, so only after they have flushed does "s == f" mean the
    // filtered level really matches the encoder's rest position.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_INIT;
            r_prev    <= '0;
            r_settle  <= '0;
            step      <= 1'b0;
            err       <= 1'b0;
            up_down   <= 1'b1;
            err_count <= '0;
            ready     <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    r_prev <= r_filt;
                    if (!w_quiet) begin
                        r_settle <= '0;
                    end else if (r_settle == C_SETTLE_MAX) begin
                        r_state <= ST_RUN;
                        ready   <= 1'b1;
                    end else begin
                        r_settle <= r_settle + C_SETTLE_W'(1);
                    end
                end
                ST_RUN: begin
                    // prev tracks even when disabled so re-enable never
                    // replays accumulated motion.
                    r_prev <= r_filt;
                    if (en) begin
                        case (w_delta)
                            2'd1: begin
                                step    <= 1'b1;
                                up_down <= 1'b1;
                            end
                            2'd3: begin
                                step    <= 1'b1;
                                up_down <= 1'b0;
                            end
                            2'd2: begin
                                err <= 1'b1;
                                if (err_count != '1) begin
                                    err_count <= err_count + ERR_CNT_W'(1);
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_quadrature_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quadrature_decoder
//  Description : Directed self-checking bench for quadrature_decoder. Each
//                driven encoder transition pushes its expected pulse (cycle,
//                kind, direction, error count) into a scoreboard queue; every
//                pulse the DUT emits is popped and compared.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_quadrature_decoder;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int ERR_CNT_W       = 8;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES + 1;
    localparam int CNT_SAT         = (1 << ERR_CNT_W) - 1;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 en = 1'b1;
    logic                 enc_a = 1'b0;
    logic                 enc_b = 1'b0;
    logic                 step;
    logic                 up_down;
    logic                 err;
    logic [ERR_CNT_W-1:0] err_count;
    logic                 ready;

    typedef struct {
        int cyc;
        bit is_err;
        bit dir;
        int cnt;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic [1:0] raw = 2'b00;
    bit         exp_dir = 1'b1;
    int         exp_cnt = 0;

    quadrature_decoder #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .ERR_CNT_W      (ERR_CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .enc_a    (enc_a),
        .enc_b    (enc_b),
        .step     (step),
        .up_down  (up_down),
        .err      (err),
        .err_count(err_count),
        .ready    (ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [1:0] up_next(input logic [1:0] v);
        case (v)
            2'b00:   return 2'b01;
            2'b01:   return 2'b11;
            2'b11:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    // One clock: sample 1 time unit after the edge and score any pulse.
    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (sb.size() > 0 && sb[0].cyc < cyc) begin
            check("missed_pulse_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (step === 1'b1 || err === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_pulse_step_err", 32'({step, err}), 32'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_step", 32'(step), 32'(!e.is_err));
                check("pulse_err", 32'(err), 32'(e.is_err));
                check("pulse_up_down", 32'(up_down), 32'(e.dir));
                check("pulse_err_count", 32'(err_count), e.cnt);
            end
        end
    endtask

    // Drive a new raw encoder level and predict the resulting pulse.
    task automatic drive(input logic [1:0] nv, input int dwell);
        exp_t e;
        if (en && nv != raw) begin
            e.cyc = cyc + LAT;
            if (nv == up_next(raw)) begin
                e.is_err = 1'b0;
                exp_dir  = 1'b1;
            end else if (raw == up_next(nv)) begin
                e.is_err = 1'b0;
                exp_dir  = 1'b0;
            end else begin
                e.is_err = 1'b1;
                if (exp_cnt < CNT_SAT) exp_cnt++;
            end
            e.dir = exp_dir;
            e.cnt = exp_cnt;
            sb.push_back(e);
        end
        raw   = nv;
        enc_a = nv[1];
        enc_b = nv[0];
        repeat (dwell) tick();
    endtask

    // Reset aborts everything in flight; outputs must be at reset values
    // right after the reset edge.
    task automatic do_reset();
        rst = 1'b1;
        sb.delete();
        exp_dir = 1'b1;
        exp_cnt = 0;
        tick();
        check("rst_step", 32'(step), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_up_down", 32'(up_down), 32'd1);
        check("rst_ready", 32'(ready), 32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        check("ready_after_init", 32'(ready), 32'd1);
        repeat (10) tick();
    endtask

    initial begin
        // 1: reset at rest 00, then a full up cycle
        do_reset();
        wait_ready();
        drive(2'b01, 20);
        drive(2'b11, 20);
        drive(2'b10, 20);
        drive(2'b00, 20);
        check("t1_up_down", 32'(up_down), 32'd1);
        check("t1_err_count", 32'(err_count), 32'd0);

        // 2: full down cycle, then one up transition
        drive(2'b10, 20);
        drive(2'b11, 20);
        drive(2'b01, 20);
        drive(2'b00, 20);
        check("t2_up_down_down", 32'(up_down), 32'd0);
        drive(2'b01, 20);
        check("t2_up_down_up", 32'(up_down), 32'd1);
        drive(2'b00, 20);

        // 3: 3-cycle glitch on A must be filtered; a following B edge must
        // then decode as a legal up step (A still filtered low)
        enc_a = 1'b1;
        repeat (3) tick();
        enc_a = 1'b0;
        repeat (20) tick();
        drive(2'b01, 20);
        drive(2'b00, 20);

        // 4: illegal transitions, then saturation of the counter
        drive(2'b11, 10);
        check("t4_err_count_one", 32'(err_count), 32'd1);
        for (int i = 0; i < 300; i++) begin
            drive((raw == 2'b11) ? 2'b00 : 2'b11, 8);
        end
        repeat (10) tick();
        check("t4_err_count_sat", 32'(err_count), CNT_SAT);
        check("t4_up_down_kept", 32'(up_down), 32'(exp_dir));

        // 5: reset with A=B=1 held, then disabled motion, then re-enable
        do_reset();
        wait_ready();
        en = 1'b0;
        drive(2'b01, 20);
        drive(2'b00, 20);
        drive(2'b10, 20);
        check("t5_up_down_frozen", 32'(up_down), 32'd1);
        en = 1'b1;
        repeat (20) tick();
        drive(2'b11, 20);
        check("t5_up_down_after_en", 32'(up_down), 32'd0);
        check("t5_err_count", 32'(err_count), 32'd0);

        // 6: reset while a transition is in flight from 11
        drive(2'b10, 3);
        do_reset();
        wait_ready();
        drive(2'b00, 20);
        check("t6_up_down", 32'(up_down), 32'd1);
        check("t6_err_count", 32'(err_count), 32'd0);

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
